// File: rtl/comp_seq_mac_if.sv
// Operand/result bundle for comp_seq_mac: the controller side drives operands and ena,
// and the MAC side returns product, running sum and the dv pulse.
interface comp_seq_mac_if #(
  parameter int unsigned p_size = 1
);
  logic [p_size-1:0]   i_param;
  logic [p_size-1:0]   i_param_2;
  logic                ena;
  logic [2*p_size-1:0] o_param;
  logic [2*p_size-1:0] o_param_2;
  logic                dv;

  modport master (
    output i_param, i_param_2, ena,
    input  o_param, o_param_2, dv
  );

  modport slave (
    input  i_param, i_param_2, ena,
    output o_param, o_param_2, dv
  );
endinterface

// File: rtl/comp_seq_mac.sv
// Unsigned shift-add multiply-accumulate: one multiplier bit per clock, LSB first,
// with a registered product, a wrapping running sum and a one-cycle dv pulse.
module comp_seq_mac #(
  parameter int unsigned p_size = 1
) (
  input  logic           clk,
  input  logic           rst,
  comp_seq_mac_if.slave  bus
);
  localparam int unsigned W  = 2 * p_size;
  localparam int unsigned CW = (p_size > 1) ? $clog2(p_size) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic [p_size-1:0] a_q, b_q;
  logic [W-1:0]    pp_q, pp_sum, a_shift;
  logic [W-1:0]    prod_q, acc_q;
  logic [CW-1:0]   cnt_q;
  logic            dv_q;
  logic            start, last;

  // Partial-product step for the multiplier bit currently selected by the counter.
  always_comb begin
    a_shift = '0;
    pp_sum  = '0;
    last    = 1'b0;
    a_shift = W'(a_q) << cnt_q;
    pp_sum  = pp_q + (b_q[cnt_q] ? a_shift : '0);
    last    = (cnt_q == CW'(p_size - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ena) begin
          start     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      pp_q   <= '0;
      cnt_q  <= '0;
      prod_q <= '0;
      acc_q  <= '0;
      dv_q   <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      if (start) begin
        a_q   <= bus.i_param;
        b_q   <= bus.i_param_2;
        pp_q  <= '0;
        cnt_q <= '0;
      end else if (state == BUSY) begin
        pp_q  <= pp_sum;
        cnt_q <= cnt_q + CW'(1);
        if (last) begin
          prod_q <= pp_sum;
          acc_q  <= acc_q + pp_sum;
          dv_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.o_param   = prod_q;
  assign bus.o_param_2 = acc_q;
  assign bus.dv        = dv_q;
endmodule

// File: tb/tb_comp_seq_mac.sv
// Scoreboard bench for comp_seq_mac at p_size=1 and p_size=4, side by side.
module tb_comp_seq_mac;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  comp_seq_mac_if #(.p_size(1)) bus1();
  comp_seq_mac_if #(.p_size(4)) bus4();

  comp_seq_mac #(.p_size(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  comp_seq_mac #(.p_size(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  typedef struct {
    int prod;
    int acc;
    int cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  int   acc1 = 0, acc4 = 0;
  int   last1 = -1, last4 = -1;
  int   n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input longint expv);
    n_chk++;
    if (act === 64'(expv)) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
  endtask

  // Monitors: every dv must match the oldest outstanding expectation, including its cycle.
  always @(negedge clk) begin
    if (rst && bus1.dv) begin
      exp_t e;
      chk("p1_dv_expected", 64'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("p1_o_param",   64'(bus1.o_param),   e.prod);
        chk("p1_o_param_2", 64'(bus1.o_param_2), e.acc);
        chk("p1_dv_cycle",  64'(cyc),            e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && bus4.dv) begin
      exp_t e;
      chk("p4_dv_expected", 64'(q4.size() > 0), 1);
      if (q4.size() > 0) begin
        e = q4.pop_front();
        chk("p4_o_param",   64'(bus4.o_param),   e.prod);
        chk("p4_o_param_2", 64'(bus4.o_param_2), e.acc);
        chk("p4_dv_cycle",  64'(cyc),            e.cyc);
      end
    end
  end

  // One clock of stimulus; the model accepts a start only when the unit is idle at the sampling edge.
  task automatic drive(input bit e1, input bit a1, input bit b1,
                       input bit e4, input logic [3:0] a4, input logic [3:0] b4);
    @(posedge clk); #1;
    bus1.ena = e1; bus1.i_param = a1; bus1.i_param_2 = b1;
    bus4.ena = e4; bus4.i_param = a4; bus4.i_param_2 = b4;
    if (e1 && (cyc + 1 > last1)) begin
      acc1 = (acc1 + int'(a1) * int'(b1)) % 4;
      q1.push_back('{prod: int'(a1) * int'(b1), acc: acc1, cyc: cyc + 2});
      last1 = cyc + 2;
    end
    if (e4 && (cyc + 1 > last4)) begin
      acc4 = (acc4 + int'(a4) * int'(b4)) % 256;
      q4.push_back('{prod: int'(a4) * int'(b4), acc: acc4, cyc: cyc + 5});
      last4 = cyc + 5;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_p1_o_param"},   64'(bus1.o_param),   0);
    chk({tag, "_p1_o_param_2"}, 64'(bus1.o_param_2), 0);
    chk({tag, "_p1_dv"},        64'(bus1.dv),        0);
    chk({tag, "_p4_o_param"},   64'(bus4.o_param),   0);
    chk({tag, "_p4_o_param_2"}, 64'(bus4.o_param_2), 0);
    chk({tag, "_p4_dv"},        64'(bus4.dv),        0);
  endtask

  // Reset aborts any outstanding work, so the model drops its expectations too.
  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    bus1.ena = 1'b0;
    bus4.ena = 1'b0;
    rst = 1'b0;
    #1 check_zero({tag, "_async"});
    q1.delete(); q4.delete();
    acc1 = 0; acc4 = 0;
    repeat (2) @(posedge clk);
    #1 check_zero({tag, "_hold"});
    rst = 1'b1;
    last1 = cyc; last4 = cyc;
  endtask

  initial begin
    bus1.ena = 1'b1; bus1.i_param = 1'($urandom); bus1.i_param_2 = 1'($urandom);
    bus4.ena = 1'b1; bus4.i_param = 4'($urandom); bus4.i_param_2 = 4'($urandom);
    #1 rst = 1'b0;
    #1 check_zero("por_async");
    @(posedge clk); #1;
    check_zero("por_hold");
    bus1.ena = 1'b0; bus4.ena = 1'b0;
    rst = 1'b1;
    last1 = cyc; last4 = cyc;

    // p_size=1: four 1*1 products, running sum wraps 1,2,3,0.
    repeat (4) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
      idle(1);
    end
    idle(2);

    // p_size=4: 13*11 then 15*15 with accumulator wrap.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd13, 4'd11);
    idle(5);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 4'd15);
    idle(6);

    // Start while busy is ignored.
    do_reset("rst_a");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd5);
    idle(1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 4'd7);
    idle(8);

    // ena held high: back-to-back operations every 5 cycles.
    do_reset("rst_b");
    repeat (11) drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd3);
    idle(6);

    // Reset during the second busy cycle aborts, then a fresh operation.
    do_reset("rst_c");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 4'd9);
    idle(1);
    do_reset("rst_mid");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd2);
    idle(6);

    // Random traffic on both units, including operand changes while busy.
    repeat (300) begin
      drive(1'($urandom % 3 != 0), 1'($urandom), 1'($urandom),
            1'($urandom % 3 != 0), 4'($urandom), 4'($urandom));
    end
    idle(8);

    chk("p1_queue_drained", 64'(q1.size()), 0);
    chk("p4_queue_drained", 64'(q4.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/comp_seq_mac.md
Name: comp_seq_mac

Overview:
- Parameterised unsigned sequential multiply-accumulate unit.
- Accepts two p_size-bit operands on an enable strobe and computes their product with a shift-add multiplier, one operand bit per clock.
- Presents the product and a running sum of all products, with a one-cycle data-valid pulse.
- Sits as a small arithmetic leaf under a controller that issues `ena` strobes and consumes `dv`.

Parameters:
- p_size, default 1, operand width in bits (legal range 1..32); result width is 2*p_size.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted); deassertion is synchronous to clk upstream.
- i_param  input  p_size  multiplicand A, unsigned.
- i_param_2  input  p_size  multiplier B, unsigned.
- ena  input  1  start strobe; sampled on rising edge only while idle.
- o_param  output  2*p_size  last completed product A*B, registered.
- o_param_2  output  2*p_size  accumulated sum of all completed products modulo 2^(2*p_size), registered.
- dv  output  1  one-cycle pulse; o_param/o_param_2 are updated in the same cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - o_param=0, o_param_2=0, dv=0.
  - Internal state goes to IDLE; bit counter, partial product and operand registers are cleared.
  - Reset asserted mid-operation aborts that operation; no dv is produced for it.
- States: IDLE, BUSY.
- IDLE:
  - dv=0 except for the completion pulse (see below).
  - On an edge with ena=1, capture A=i_param and B=i_param_2, clear the partial product, set the counter to 0, and go to BUSY.
  - ena=0 keeps IDLE; outputs hold.
- BUSY: each edge processes one bit of B, LSB first:
  - If B[k]=1, add A<<k into the 2*p_size-bit partial product.
  - Increment k.
  - ena is ignored; operand input changes have no effect.
- Completion:
  - On the edge that processes bit k=p_size-1 (the p_size-th BUSY edge):
    - o_param <= final product.
    - o_param_2 <= o_param_2 + final product, truncated to 2*p_size bits (wrap, no saturation, no carry-out).
    - dv <= 1.
    - State goes to IDLE.
  - dv is high for exactly one cycle and returns to 0 on the next edge, unless a new operation completes then; it cannot, because p_size ≥ 1.
- Latency: ena sampled at edge N → dv=1 and outputs valid after edge N+p_size. For p_size=1: the edge after the ena edge.
- Throughput:
  - ena may be high in the cycle where dv=1; since the state is IDLE then, it is accepted.
  - Peak rate is one operation per p_size+1 clocks.
- ena held high continuously starts a new operation on every IDLE edge.
- Width rules:
  - All arithmetic is unsigned.
  - Product never overflows 2*p_size bits.
  - Only the accumulator wraps.
- Between operations o_param and o_param_2 hold their values.
- The accumulator is cleared only by reset.
- No X propagation: every register has a reset value.

Test Plan:
- Reset: drive rst=0 with random inputs and ena=1 → o_param=0, o_param_2=0, dv=0 immediately (asynchronous, before any clock edge); these hold while rst=0.
- p_size=1: A=1, B=1, ena pulse at edge N → dv=1 after edge N+1, o_param=2'b01, o_param_2=2'b01. Repeat 3 more times → o_param_2 wraps: 2,3,0.
- p_size=4: A=13, B=11 → dv after 4 edges, o_param=8'h8F (143), o_param_2=143. Then A=15, B=15 → o_param=225, o_param_2=112 (368 mod 256).
- p_size=4 busy-ignore: start A=3, B=5; pulse ena with A=7, B=7 two cycles later → single dv, o_param=15; no second result appears.
- p_size=4 back-to-back: ena held high for 3 operations with A=2, B=3 → dv pulses spaced 5 cycles apart, o_param_2 = 6, 12, 18.
- Reset mid-operation: p_size=4, A=9, B=9, assert rst=0 on the 2nd BUSY cycle, release → no dv, outputs 0. The next operation (A=2, B=2) gives o_param=4, o_param_2=4.
